fft_stream_frame_ctrl: RTL and testbench
========================================

Name: fft_stream_frame_ctrl

Overview:
- Parametrised frame controller that turns the fixed 8-point parallel FFT pipeline into a streaming block with valid/ready handshakes.
- Input side: accepts one complex sample per cycle and assembles an N_POINTS frame.
- Datapath side: launches the frame into the external parallel pipelined FFT datapath, then tracks it through PIPE_LAT register stages.
- Output side: captures the result and serialises it with an index and a last flag.
- Replaces the counter-only start/done control with real flow control, framing checks and an optional inverse mode.

Parameters:
- WIDTH, 16, bits per real/imag component (signed).
- N_POINTS, 8, FFT size; power of two, 4..64.
- PIPE_LAT, 3, datapath latency in cycles from dp_in_valid to result, >=1.
- IDX_W, $clog2(N_POINTS), index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample accepted when s_valid&&s_ready.
- s_real  in  WIDTH  input real.
- s_imag  in  WIDTH  input imag.
- s_last  in  1  marks final sample of frame.
- dp_in_valid  out  1  one-cycle frame launch to datapath.
- dp_in_real  out  N_POINTS*WIDTH  packed frame real, sample k at [k*WIDTH+:WIDTH].
- dp_in_imag  out  N_POINTS*WIDTH  packed frame imag.
- dp_out_real  in  N_POINTS*WIDTH  datapath result real, valid PIPE_LAT cycles after launch.
- dp_out_imag  in  N_POINTS*WIDTH  datapath result imag.
- m_valid  out  1  output sample valid.
- m_ready  in  1  downstream accept.
- m_real  out  WIDTH  output real.
- m_imag  out  WIDTH  output imag.
- m_index  out  IDX_W  bin index of current output.
- m_last  out  1  high with bin N_POINTS-1.
- frame_err  out  1  one-cycle pulse on framing error.
- busy  out  1  any frame held in loader, pipeline or output buffer.

Behaviour:
- Reset: clk and rst_n as named; reset is synchronous, active-low. All outputs 0 at reset, except s_ready=1 on the first cycle after reset. Indices, buffers, in-flight shift register and error flag are all cleared.
- Loader FSM, LOAD -> FULL:
  - LOAD: s_ready=1; each accepted beat writes ibuf[wr_idx] and increments wr_idx.
  - Beat at wr_idx=N_POINTS-1 goes to FULL and clears wr_idx.
  - FULL: s_ready=0; holds until launch, then returns to LOAD.
- Framing:
  - s_last on a beat with wr_idx<N_POINTS-1: frame_err pulses next cycle, partial frame is discarded, wr_idx=0, stays in LOAD.
  - s_last low on beat N_POINTS-1: frame_err pulses, frame is still accepted.
- Launch condition: FULL && no frame in flight && (obuf empty, or obuf last beat handshaking this cycle). dp_in_valid is high exactly that cycle, and dp_in_* drives ibuf contents. One frame in flight maximum.
- In-flight tracker: PIPE_LAT-bit shift register seeded by dp_in_valid. When its tail bit is high, dp_out_* is captured into obuf.
- Unloader FSM, IDLE -> DRAIN:
  - DRAIN: m_valid=1, m_real/m_imag=obuf[rd_idx], m_index=rd_idx, m_last=(rd_idx==N_POINTS-1).
  - rd_idx advances only on m_valid&&m_ready. Outputs are held stable while m_ready=0.
  - After the last beat: IDLE, m_valid=0 next cycle.
- Latency, no stalls: last input beat at cycle t gives launch at t+1, capture at t+1+PIPE_LAT, first m_valid at t+2+PIPE_LAT.
- Simultaneous: obuf last beat accepted and capture in the same cycle is impossible by the launch rule. Last-beat handshake and launch in the same cycle is legal.
- Reset mid-frame: all partial and in-flight data is dropped. dp_out_* arriving after reset is ignored.
- busy = (loader!=LOAD || wr_idx!=0) || tracker!=0 || unloader==DRAIN.

Optional Feature:
- Macro FFT_INVERSE_EN: adds input port inv (1 bit), sampled at launch and carried with the frame.
  - With inv=1: real/imag are swapped on dp_in_* and again on m_*.
  - Outputs are arithmetically shifted right by log2(N_POINTS), rounding to nearest, ties away from zero.
- Without the macro: no inv port, no swap, no shift.

Decomposition:
- Shared package fft_pkg:
  - loader/unloader state enums.
  - WIDTH/N_POINTS defaults.
  - complex sample typedef {real, imag}.
  - function clog2.
- One natural sub-module: fft_frame_buffer, an N_POINTS-entry complex register array with indexed write and packed parallel read/load. Instantiated twice (ibuf, obuf).

Test Plan:
- Impulse: 8 beats (1.0 at k=0, Q12 0x1000, else 0), PIPE_LAT=3, stub datapath = identity, m_ready=1 -> dp_in_valid at t+1. m_valid at t+5, indices 0..7 stream back-to-back, m_last on index 7.
- Backpressure: m_ready toggles 1,0,0,1 … -> no output beat lost or duplicated; m_real stable while stalled. A second frame fully loaded stays in FULL with s_ready=0 until the obuf last-beat handshake.
- Early s_last on beat 3 -> frame_err pulse one cycle, no dp_in_valid. The next clean 8-beat frame launches normally.
- Missing s_last on beat 7 -> frame_err pulse, frame still launched and output.
- rst_n low for one cycle mid-DRAIN at index 4 -> m_valid=0, busy=0, s_ready=1 next cycle. No stale output on the following frame.
- FFT_INVERSE_EN, inv=1, identity datapath, input constant 0x0800+j0 -> outputs real 0x0100, imag 0 for all 8 bins.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types, defaults and helpers for the streaming FFT frame controller.
package fft_pkg;

  localparam int unsigned WIDTH_DEF    = 16;
  localparam int unsigned N_POINTS_DEF = 8;

  // Loader states
  localparam logic [0:0] LD_LOAD = 1'b0;
  localparam logic [0:0] LD_FULL = 1'b1;

  // Unloader states
  localparam logic [0:0] UL_IDLE  = 1'b0;
  localparam logic [0:0] UL_DRAIN = 1'b1;

  typedef struct packed {
    logic signed [WIDTH_DEF-1:0] re;
    logic signed [WIDTH_DEF-1:0] im;
  } cplx_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) begin
      res++;
    end
    return res;
  endfunction

endpackage

// File: rtl/fft_frame_buffer.sv
// N-entry complex register array: indexed single-sample write, whole-frame parallel load/read.
module fft_frame_buffer #(
  parameter int unsigned Width   = 16,
  parameter int unsigned NPoints = 8,
  parameter int unsigned IdxW    = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr_en_i,
  input  logic [IdxW-1:0]          wr_idx_i,
  input  logic [Width-1:0]         wr_real_i,
  input  logic [Width-1:0]         wr_imag_i,
  input  logic                     load_en_i,
  input  logic [NPoints*Width-1:0] load_real_i,
  input  logic [NPoints*Width-1:0] load_imag_i,
  output logic [NPoints*Width-1:0] rd_real_o,
  output logic [NPoints*Width-1:0] rd_imag_o
);

  logic [NPoints*Width-1:0] re_q, re_d;
  logic [NPoints*Width-1:0] im_q, im_d;

  always_comb begin
    re_d = re_q;
    im_d = im_q;
    if (load_en_i) begin
      re_d = load_real_i;
      im_d = load_imag_i;
    end else if (wr_en_i) begin
      for (int unsigned k = 0; k < NPoints; k++) begin
        if (wr_idx_i == IdxW'(k)) begin
          re_d[k*Width +: Width] = wr_real_i;
          im_d[k*Width +: Width] = wr_imag_i;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      re_q <= '0;
      im_q <= '0;
    end else begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  assign rd_real_o = re_q;
  assign rd_imag_o = im_q;

endmodule

// File: rtl/fft_stream_frame_ctrl.sv
// Valid/ready frame controller around an external parallel pipelined FFT datapath.
// Define FFT_INVERSE_EN to add the inv port (swap in/out plus scaled, rounded output).
module fft_stream_frame_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned N_POINTS = N_POINTS_DEF,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned IDX_W    = $clog2(N_POINTS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [WIDTH-1:0]          s_real,
  input  logic [WIDTH-1:0]          s_imag,
  input  logic                      s_last,
`ifdef FFT_INVERSE_EN
  input  logic                      inv,
`endif
  output logic                      dp_in_valid,
  output logic [N_POINTS*WIDTH-1:0] dp_in_real,
  output logic [N_POINTS*WIDTH-1:0] dp_in_imag,
  input  logic [N_POINTS*WIDTH-1:0] dp_out_real,
  input  logic [N_POINTS*WIDTH-1:0] dp_out_imag,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [WIDTH-1:0]          m_real,
  output logic [WIDTH-1:0]          m_imag,
  output logic [IDX_W-1:0]          m_index,
  output logic                      m_last,
  output logic                      frame_err,
  output logic                      busy
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N_POINTS - 1);

  logic                 ld_q, ld_d;
  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  logic                 err_q, err_d;
  logic                 ul_q, ul_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic [PIPE_LAT-1:0]  trk_q, trk_d;

  logic accept, ibuf_wr, launch, capture, last_hs;
  logic [N_POINTS*WIDTH-1:0] ibuf_re, ibuf_im, obuf_re, obuf_im;
  logic [WIDTH-1:0] sel_re, sel_im, out_re, out_im;

  assign s_ready = (ld_q == LD_LOAD);
  assign accept  = s_valid && s_ready;
  // An early s_last drops the beat along with the rest of the partial frame.
  assign ibuf_wr = accept && !(s_last && (wr_idx_q != LastIdx));
  assign m_valid = (ul_q == UL_DRAIN);
  assign last_hs = m_valid && m_ready && (rd_idx_q == LastIdx);
  assign launch  = (ld_q == LD_FULL) && (trk_q == '0) && (!m_valid || last_hs);
  assign capture = trk_q[PIPE_LAT-1];

  always_comb begin
    ld_d     = ld_q;
    wr_idx_d = wr_idx_q;
    err_d    = 1'b0;
    if (ld_q == LD_LOAD) begin
      if (accept) begin
        if (wr_idx_q == LastIdx) begin
          ld_d     = LD_FULL;
          wr_idx_d = '0;
          err_d    = !s_last;
        end else if (s_last) begin
          wr_idx_d = '0;
          err_d    = 1'b1;
        end else begin
          wr_idx_d = wr_idx_q + IDX_W'(1);
        end
      end
    end else if (launch) begin
      ld_d = LD_LOAD;
    end
  end

  assign trk_d = (trk_q << 1) | PIPE_LAT'(launch);

  always_comb begin
    ul_d     = ul_q;
    rd_idx_d = rd_idx_q;
    if (capture) begin
      ul_d     = UL_DRAIN;
      rd_idx_d = '0;
    end else if (m_valid && m_ready) begin
      if (rd_idx_q == LastIdx) begin
        ul_d     = UL_IDLE;
        rd_idx_d = '0;
      end else begin
        rd_idx_d = rd_idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ld_q     <= LD_LOAD;
      wr_idx_q <= '0;
      err_q    <= 1'b0;
      ul_q     <= UL_IDLE;
      rd_idx_q <= '0;
      trk_q    <= '0;
    end else begin
      ld_q     <= ld_d;
      wr_idx_q <= wr_idx_d;
      err_q    <= err_d;
      ul_q     <= ul_d;
      rd_idx_q <= rd_idx_d;
      trk_q    <= trk_d;
    end
  end

  fft_frame_buffer #(
    .Width   (WIDTH),
    .NPoints (N_POINTS),
    .IdxW    (IDX_W)
  ) u_ibuf (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wr_en_i     (ibuf_wr),
    .wr_idx_i    (wr_idx_q),
    .wr_real_i   (s_real),
    .wr_imag_i   (s_imag),
    .load_en_i   (1'b0),
    .load_real_i ('0),
    .load_imag_i ('0),
    .rd_real_o   (ibuf_re),
    .rd_imag_o   (ibuf_im)
  );

  fft_frame_buffer #(
    .Width   (WIDTH),
    .NPoints (N_POINTS),
    .IdxW    (IDX_W)
  ) u_obuf (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wr_en_i     (1'b0),
    .wr_idx_i    ('0),
    .wr_real_i   ('0),
    .wr_imag_i   ('0),
    .load_en_i   (capture),
    .load_real_i (dp_out_real),
    .load_imag_i (dp_out_imag),
    .rd_real_o   (obuf_re),
    .rd_imag_o   (obuf_im)
  );

  always_comb begin
    sel_re = '0;
    sel_im = '0;
    for (int unsigned k = 0; k < N_POINTS; k++) begin
      if (rd_idx_q == IDX_W'(k)) begin
        sel_re = obuf_re[k*WIDTH +: WIDTH];
        sel_im = obuf_im[k*WIDTH +: WIDTH];
      end
    end
  end

`ifdef FFT_INVERSE_EN
  localparam int unsigned Shift = clog2(N_POINTS);

  logic inv_fl_q, inv_out_q;

  // Scale by 1/N on the magnitude so ties round away from zero.
  function automatic logic [WIDTH-1:0] rnd_shift(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] ext, mag, sum;
    ext = {x[WIDTH-1], x};
    mag = x[WIDTH-1] ? (~ext + 1'b1) : ext;
    sum = (mag + (WIDTH+1)'(32'd1 << (Shift - 1))) >> Shift;
    return x[WIDTH-1] ? WIDTH'(~sum + 1'b1) : WIDTH'(sum);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inv_fl_q  <= 1'b0;
      inv_out_q <= 1'b0;
    end else begin
      if (launch)  inv_fl_q  <= inv;
      if (capture) inv_out_q <= inv_fl_q;
    end
  end

  assign dp_in_real = inv ? ibuf_im : ibuf_re;
  assign dp_in_imag = inv ? ibuf_re : ibuf_im;
  assign out_re     = inv_out_q ? rnd_shift(sel_im) : sel_re;
  assign out_im     = inv_out_q ? rnd_shift(sel_re) : sel_im;
`else
  assign dp_in_real = ibuf_re;
  assign dp_in_imag = ibuf_im;
  assign out_re     = sel_re;
  assign out_im     = sel_im;
`endif

  assign dp_in_valid = launch;
  assign m_real      = m_valid ? out_re : '0;
  assign m_imag      = m_valid ? out_im : '0;
  assign m_index     = rd_idx_q;
  assign m_last      = m_valid && (rd_idx_q == LastIdx);
  assign frame_err   = err_q;
  assign busy        = (ld_q != LD_LOAD) || (wr_idx_q != '0) || (trk_q != '0) || m_valid;

endmodule

// File: tb/tb_fft_stream_frame_ctrl.sv
// Self-checking bench for fft_stream_frame_ctrl: frame-level scoreboard plus directed scenarios.
// Honours FFT_INVERSE_EN the same way as the design.
module tb_fft_stream_frame_ctrl;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int L  = 3;
  localparam int IW = 3;

  typedef struct packed {
    logic         inv;
    logic [N*W-1:0] re;
    logic [N*W-1:0] im;
  } frame_t;

  logic clk, rst_n;
  logic s_valid, s_ready, s_last;
  logic [W-1:0] s_real, s_imag;
  logic dp_in_valid;
  logic [N*W-1:0] dp_in_real, dp_in_imag, dp_out_real, dp_out_imag;
  logic m_valid, m_ready, m_last, frame_err, busy;
  logic [W-1:0] m_real, m_imag;
  logic [IW-1:0] m_index;
`ifdef FFT_INVERSE_EN
  logic inv;
`endif

  int errors = 0;
  int checks = 0;
  int rdy_mode = 0;  // 0: ready, 1: stalled, 2: 1,0,0,1 pattern, 3: random
  bit mon_en = 0;

  fft_stream_frame_ctrl #(
    .WIDTH    (W),
    .N_POINTS (N),
    .PIPE_LAT (L),
    .IDX_W    (IW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_real      (s_real),
    .s_imag      (s_imag),
    .s_last      (s_last),
`ifdef FFT_INVERSE_EN
    .inv         (inv),
`endif
    .dp_in_valid (dp_in_valid),
    .dp_in_real  (dp_in_real),
    .dp_in_imag  (dp_in_imag),
    .dp_out_real (dp_out_real),
    .dp_out_imag (dp_out_imag),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_real      (m_real),
    .m_imag      (m_imag),
    .m_index     (m_index),
    .m_last      (m_last),
    .frame_err   (frame_err),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Identity datapath with L stages; outside the result cycle it drives junk.
  logic [N*W-1:0] pre [L];
  logic [N*W-1:0] pim [L];
  logic [L-1:0]   pv;
  logic [N*W-1:0] junk_re, junk_im;
  always @(posedge clk) begin
    pv     <= {pv[L-2:0], dp_in_valid};
    pre[0] <= dp_in_real;
    pim[0] <= dp_in_imag;
    for (int k = 1; k < L; k++) begin
      pre[k] <= pre[k-1];
      pim[k] <= pim[k-1];
    end
    for (int k = 0; k < N; k++) begin
      junk_re[k*W +: W] <= W'($urandom);
      junk_im[k*W +: W] <= W'($urandom);
    end
  end
  assign dp_out_real = pv[L-1] ? pre[L-1] : junk_re;
  assign dp_out_imag = pv[L-1] ? pim[L-1] : junk_im;

  initial begin
    logic [3:0] pat;
    int pc;
    pat = 4'b1001;
    pc = 0;
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: m_ready = 1'b1;
        1: m_ready = 1'b0;
        2: begin m_ready = pat[3 - (pc % 4)]; pc++; end
        default: m_ready = 1'(($urandom % 3) != 0);
      endcase
    end
  end

  // Reference: inverse result through an identity datapath is the input divided by N,
  // rounded to nearest with ties away from zero.
  function automatic logic [W-1:0] ref_scale(input logic [W-1:0] x);
    int v, a;
    v = int'($signed(x));
    a = (v < 0) ? -v : v;
    a = (a + N / 2) / N;
    return W'((v < 0) ? -a : a);
  endfunction

  // Scoreboard, sampled mid-cycle.
  frame_t launch_q[$];
  frame_t out_q[$];
  frame_t f;
  int cnt = 0;
  int out_idx = 0;
  logic [N*W-1:0] acc_re, acc_im;
  logic err_pend = 1'b0;
  logic prev_stall = 1'b0;
  logic [W-1:0] prev_re, prev_im, exp_re, exp_im;

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (frame_err !== err_pend) begin
        errors++;
        $display("FAIL frame_err t=%0t got=%b want=%b", $time, frame_err, err_pend);
      end
      err_pend = 1'b0;
      if (!rst_n) begin
        launch_q.delete();
        out_q.delete();
        cnt = 0;
        out_idx = 0;
        prev_stall = 1'b0;
      end else begin
        if (dp_in_valid === 1'b1) begin
          checks++;
          if (launch_q.size() == 0) begin
            errors++;
            $display("FAIL launch_spurious t=%0t got=1 want=0", $time);
          end else begin
            f = launch_q.pop_front();
            if (dp_in_real !== (f.inv ? f.im : f.re) || dp_in_imag !== (f.inv ? f.re : f.im)) begin
              errors++;
              $display("FAIL launch_data t=%0t got=%h want=%h", $time, dp_in_real,
                       f.inv ? f.im : f.re);
            end
            out_q.push_back(f);
          end
        end
        if (prev_stall) begin
          checks++;
          if (m_real !== prev_re || m_imag !== prev_im) begin
            errors++;
            $display("FAIL stall_hold t=%0t got=%h/%h want=%h/%h", $time, m_real, m_imag,
                     prev_re, prev_im);
          end
        end
        prev_stall = 1'b0;
        if (m_valid === 1'b1) begin
          checks++;
          if (out_q.size() == 0) begin
            errors++;
            $display("FAIL out_stale t=%0t got=m_valid want=idle", $time);
          end else begin
            exp_re = out_q[0].re[out_idx*W +: W];
            exp_im = out_q[0].im[out_idx*W +: W];
            if (out_q[0].inv) begin
              exp_re = ref_scale(exp_re);
              exp_im = ref_scale(exp_im);
            end
            if (m_real !== exp_re || m_imag !== exp_im || m_index !== IW'(out_idx) ||
                m_last !== (out_idx == N - 1)) begin
              errors++;
              $display("FAIL out_beat t=%0t got=%h/%h idx%0d last%b want=%h/%h idx%0d last%b",
                       $time, m_real, m_imag, m_index, m_last, exp_re, exp_im, out_idx,
                       (out_idx == N - 1));
            end
            if (m_ready === 1'b1) begin
              if (out_idx == N - 1) begin
                void'(out_q.pop_front());
                out_idx = 0;
              end else begin
                out_idx++;
              end
            end else begin
              prev_stall = 1'b1;
              prev_re = m_real;
              prev_im = m_imag;
            end
          end
        end
        if (s_valid === 1'b1 && s_ready === 1'b1) begin
          if (cnt == N - 1) begin
            acc_re[cnt*W +: W] = s_real;
            acc_im[cnt*W +: W] = s_imag;
            f.re  = acc_re;
            f.im  = acc_im;
            f.inv = 1'b0;
`ifdef FFT_INVERSE_EN
            f.inv = inv;
`endif
            launch_q.push_back(f);
            err_pend = !s_last;
            cnt = 0;
          end else if (s_last) begin
            err_pend = 1'b1;
            cnt = 0;
          end else begin
            acc_re[cnt*W +: W] = s_real;
            acc_im[cnt*W +: W] = s_imag;
            cnt++;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [W-1:0] re, input logic [W-1:0] im, input logic last);
    int guard;
    guard = 0;
    s_valid = 1'b1;
    s_real  = re;
    s_imag  = im;
    s_last  = last;
    while (s_ready !== 1'b1 && guard < 300) begin
      step();
      guard++;
    end
    checks++;
    if (guard >= 300) begin
      errors++;
      $display("FAIL s_ready_timeout got=%b want=1", s_ready);
    end
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Sends nbeats beats; s_last rides on beat last_at (-1: never).
  task automatic send_frame(input logic [N*W-1:0] re, input logic [N*W-1:0] im,
                            input int nbeats, input int last_at);
    for (int b = 0; b < nbeats; b++) begin
      drive_beat(re[b*W +: W], im[b*W +: W], 1'(b == last_at));
    end
  endtask

  task automatic rand_frame(output logic [N*W-1:0] re, output logic [N*W-1:0] im);
    for (int k = 0; k < N; k++) begin
      re[k*W +: W] = W'($urandom);
      im[k*W +: W] = W'($urandom);
    end
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_idle_timeout got busy=%b want=0", name, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) step();
    checks++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0 || dp_in_valid !== 1'b0 || frame_err !== 1'b0 ||
        busy !== 1'b0 || m_last !== 1'b0 || m_index !== '0 || m_real !== '0 || m_imag !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy%b mv%b dv%b fe%b busy%b last%b idx%0d re%h want 1000000",
               s_ready, m_valid, dp_in_valid, frame_err, busy, m_last, m_index, m_real);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    step();
  endtask

  task automatic test_impulse();
    logic [N*W-1:0] re, im;
    re = '0;
    im = '0;
    re[W-1:0] = 16'h1000;
    rdy_mode = 0;
    step();
    send_frame(re, im, N, N - 1);
    checks++;
    if (dp_in_valid !== 1'b1 || dp_in_real !== re || dp_in_imag !== im) begin
      errors++;
      $display("FAIL impulse_launch got dv=%b re=%h want dv=1 re=%h", dp_in_valid, dp_in_real, re);
    end
    repeat (L) step();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL impulse_early_valid got=%b want=0", m_valid);
    end
    step();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (m_valid !== 1'b1 || m_index !== IW'(i) || m_last !== 1'(i == N - 1)) begin
        errors++;
        $display("FAIL impulse_stream got mv%b idx%0d last%b want mv1 idx%0d last%b",
                 m_valid, m_index, m_last, i, (i == N - 1));
      end
      step();
    end
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL impulse_end got mv%b busy%b want 00", m_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [N*W-1:0] re, im;
    int n;
    rdy_mode = 1;
    rand_frame(re, im);
    send_frame(re, im, N, N - 1);
    n = 0;
    while (m_valid !== 1'b1 && n < 30) begin step(); n++; end
    rand_frame(re, im);
    send_frame(re, im, N, N - 1);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s_ready !== 1'b0 || dp_in_valid !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_full_hold got rdy%b dv%b busy%b want 001", s_ready, dp_in_valid, busy);
      end
      step();
    end
    rdy_mode = 2;
    n = 0;
    @(negedge clk);
    while (!(m_valid === 1'b1 && m_ready === 1'b1 && m_last === 1'b1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dp_in_valid !== 1'b1 || n >= 100) begin
      errors++;
      $display("FAIL bp_launch_on_last got dv=%b waited=%0d want dv=1", dp_in_valid, n);
    end
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_reload got s_ready=%b want=1", s_ready);
    end
    step();
    wait_idle(200, "bp");
  endtask

  task automatic test_early_last();
    logic [N*W-1:0] re, im;
    rdy_mode = 0;
    rand_frame(re, im);
    send_frame(re, im, 4, 3);
    checks++;
    if (frame_err !== 1'b1 || dp_in_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL early_last got fe%b dv%b busy%b rdy%b want 1001", frame_err, dp_in_valid,
               busy, s_ready);
    end
    step();
    checks++;
    if (frame_err !== 1'b0) begin
      errors++;
      $display("FAIL early_last_pulse got fe=%b want=0", frame_err);
    end
    rand_frame(re, im);
    send_frame(re, im, N, N - 1);
    wait_idle(60, "early_next");
  endtask

  task automatic test_missing_last();
    logic [N*W-1:0] re, im;
    rdy_mode = 0;
    rand_frame(re, im);
    send_frame(re, im, N, -1);
    checks++;
    if (frame_err !== 1'b1 || dp_in_valid !== 1'b1) begin
      errors++;
      $display("FAIL missing_last got fe%b dv%b want 11", frame_err, dp_in_valid);
    end
    wait_idle(60, "missing");
  endtask

  task automatic test_reset_drain();
    logic [N*W-1:0] re, im;
    int n;
    rdy_mode = 0;
    rand_frame(re, im);
    send_frame(re, im, N, N - 1);
    n = 0;
    while (!(m_valid === 1'b1 && m_index === IW'(4)) && n < 30) begin step(); n++; end
    rst_n = 1'b0;
    step();
    checks++;
    if (m_valid !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b1 || n >= 30) begin
      errors++;
      $display("FAIL reset_drain got mv%b busy%b rdy%b waited=%0d want 001", m_valid, busy,
               s_ready, n);
    end
    rst_n = 1'b1;
    // Reset again while a frame is inside the datapath; its late result must be ignored.
    rand_frame(re, im);
    send_frame(re, im, N, N - 1);
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (L + 3) begin
      checks++;
      if (m_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_inflight got mv=%b want=0", m_valid);
      end
      step();
    end
    rand_frame(re, im);
    send_frame(re, im, N, N - 1);
    wait_idle(60, "reset_next");
  endtask

  task automatic test_random();
    logic [N*W-1:0] re, im;
    rdy_mode = 3;
    for (int fr = 0; fr < 8; fr++) begin
      rand_frame(re, im);
      if ($urandom_range(4) == 0) begin
        send_frame(re, im, 2 + $urandom_range(4), 1 + $urandom_range(4));
      end else begin
        send_frame(re, im, N, N - 1);
      end
      repeat ($urandom_range(3)) step();
    end
    wait_idle(600, "random");
    rdy_mode = 0;
  endtask

`ifdef FFT_INVERSE_EN
  task automatic test_inverse();
    logic [N*W-1:0] re, im;
    int n;
    rdy_mode = 0;
    inv = 1'b1;
    for (int k = 0; k < N; k++) begin
      re[k*W +: W] = 16'h0800;
      im[k*W +: W] = 16'h0000;
    end
    send_frame(re, im, N, N - 1);
    n = 0;
    while (m_valid !== 1'b1 && n < 30) begin step(); n++; end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (m_real !== 16'h0100 || m_imag !== 16'h0000) begin
        errors++;
        $display("FAIL inverse_bin%0d got=%h/%h want=0100/0000", i, m_real, m_imag);
      end
      step();
    end
    rand_frame(re, im);
    send_frame(re, im, N, N - 1);
    wait_idle(60, "inverse");
    inv = 1'b0;
  endtask
`endif

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_real  = '0;
    s_imag  = '0;
`ifdef FFT_INVERSE_EN
    inv = 1'b0;
`endif
    test_reset();
    test_impulse();
    test_backpressure();
    test_early_last();
    test_missing_last();
    test_reset_drain();
    test_random();
`ifdef FFT_INVERSE_EN
    test_inverse();
`endif
    repeat (3) step();
    checks++;
    if (launch_q.size() != 0 || out_q.size() != 0) begin
      errors++;
      $display("FAIL frames_lost got pending=%0d/%0d want=0/0", launch_q.size(), out_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
